// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scanner
// Brief    : Four-digit common-anode hex scanner with frame latch and blanking.
// Revision : 1.0
// ============================================================================

module seven_seg_scanner #(
    parameter int BLANK_CYCLES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        div_clock,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam bit         c_no_blank = (BLANK_CYCLES == 0);
    localparam logic [7:0] c_cnt_last = c_no_blank ? 8'd0 : 8'(BLANK_CYCLES - 1);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic        sync0_q, sync0_d;
    logic        sync1_q, sync1_d;
    logic        prev_q, prev_d;
    logic        fill0_q, fill0_d;
    logic        fill1_q, fill1_d;
    logic        armed_q, armed_d;
    state_t      state_q, state_d;
    logic [1:0]  index_q, index_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] frame_value_q, frame_value_d;
    logic [3:0]  frame_dp_q, frame_dp_d;
    logic [3:0]  frame_blank_q, frame_blank_d;
    logic [3:0]  anode_q, anode_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;

    logic        tick;
    logic        capture;
    logic [3:0]  nibble;

    // Synchronizer plus arming: a tick is only allowed once a genuine low has
    // been seen on sync1, so a div_clock already high at reset release is ignored.
    always_comb begin
        sync0_d = div_clock;
        sync1_d = sync0_q;
        prev_d  = sync1_q;
        fill0_d = 1'b1;
        fill1_d = fill0_q;
        armed_d = armed_q | (fill1_q & ~sync1_q);
        tick    = sync1_q & ~prev_q & armed_q;
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        capture = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (tick) begin
                    index_d = 2'd0;
                    capture = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = c_no_blank ? ST_SHOW : ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (cnt_q == c_cnt_last) begin
                    cnt_d   = 8'd0;
                    state_d = ST_SHOW;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SHOW: begin
                if (tick) begin
                    index_d = index_q + 2'd1;
                    capture = (index_d == 2'd0);
                    cnt_d   = 8'd0;
                    state_d = c_no_blank ? ST_SHOW : ST_BLANK;
                end
            end
            default: begin
                state_d = ST_WAIT;
                index_d = 2'd0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        frame_value_d = frame_value_q;
        frame_dp_d    = frame_dp_q;
        frame_blank_d = frame_blank_q;
        if (capture) begin
            frame_value_d = value;
            frame_dp_d    = dp_in;
            frame_blank_d = blank_in;
        end
    end

    // Outputs are decoded from next-state values so the registered anode
    // changes in the same edge as the state, giving a clean one-cold hand-off.
    always_comb begin
        nibble  = frame_value_d[{index_d, 2'b00} +: 4];
        anode_d = 4'b1111;
        seg_d   = 7'b1111111;
        dp_d    = 1'b1;
        if (state_d == ST_SHOW && !frame_blank_d[index_d]) begin
            anode_d          = 4'b1111;
            anode_d[index_d] = 1'b0;
            seg_d            = hex_to_seg(nibble);
            dp_d             = ~frame_dp_d[index_d];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync0_q       <= 1'b0;
            sync1_q       <= 1'b0;
            prev_q        <= 1'b0;
            fill0_q       <= 1'b0;
            fill1_q       <= 1'b0;
            armed_q       <= 1'b0;
            state_q       <= ST_WAIT;
            index_q       <= 2'd0;
            cnt_q         <= 8'd0;
            frame_value_q <= 16'd0;
            frame_dp_q    <= 4'd0;
            frame_blank_q <= 4'd0;
            anode_q       <= 4'b1111;
            seg_q         <= 7'b1111111;
            dp_q          <= 1'b1;
        end else begin
            sync0_q       <= sync0_d;
            sync1_q       <= sync1_d;
            prev_q        <= prev_d;
            fill0_q       <= fill0_d;
            fill1_q       <= fill1_d;
            armed_q       <= armed_d;
            state_q       <= state_d;
            index_q       <= index_d;
            cnt_q         <= cnt_d;
            frame_value_q <= frame_value_d;
            frame_dp_q    <= frame_dp_d;
            frame_blank_q <= frame_blank_d;
            anode_q       <= anode_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign anode = anode_q;
    assign seg   = seg_q;
    assign dp    = dp_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scanner
// Brief    : Directed bench for seven_seg_scanner (BLANK_CYCLES 8 and 0).
// Revision : 1.0
// ============================================================================

module tb_seven_seg_scanner;

    localparam logic [11:0] OFF = 12'hFFF;

    logic        clock = 1'b0;
    logic        reset;
    logic        div_clock;
    logic        div_clock0;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [15:0] value0;
    logic [3:0]  dp_in0;
    logic [3:0]  blank_in0;
    logic [3:0]  anode, anode0;
    logic [6:0]  seg, seg0;
    logic        dp, dp0;

    int          tests = 0;
    int          fails = 0;
    logic [11:0] cur [2];

    always #5 clock = ~clock;

    seven_seg_scanner #(.BLANK_CYCLES(8)) u_dut (
        .clock(clock), .reset(reset), .div_clock(div_clock),
        .value(value), .dp_in(dp_in), .blank_in(blank_in),
        .anode(anode), .seg(seg), .dp(dp)
    );

    seven_seg_scanner #(.BLANK_CYCLES(0)) u_dut0 (
        .clock(clock), .reset(reset), .div_clock(div_clock0),
        .value(value0), .dp_in(dp_in0), .blank_in(blank_in0),
        .anode(anode0), .seg(seg0), .dp(dp0)
    );

    function automatic logic [11:0] vec(input logic [3:0] a, input logic [6:0] s, input logic d);
        return {a, s, d};
    endfunction

    function automatic logic [11:0] obs(input bit zb);
        return zb ? {anode0, seg0, dp0} : {anode, seg, dp};
    endfunction

    task automatic check(input string tag, input logic [11:0] o, input logic [11:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Called at a falling clock edge; raises div_clock and follows the tick.
    task automatic tick_step(input bit zb, input logic [11:0] nxt, input string tag);
        if (zb) div_clock0 = 1'b1; else div_clock = 1'b1;
        @(negedge clock);
        check({tag, "/hold1"}, obs(zb), cur[zb]);
        @(negedge clock);
        check({tag, "/hold2"}, obs(zb), cur[zb]);
        if (!zb) begin
            repeat (8) begin
                @(negedge clock);
                check({tag, "/blank"}, obs(zb), OFF);
            end
        end
        @(negedge clock);
        check({tag, "/digit"}, obs(zb), nxt);
        cur[zb] = nxt;
        if (zb) div_clock0 = 1'b0; else div_clock = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        div_clock  = 1'b0;
        div_clock0 = 1'b0;
        value      = 16'h0000;
        dp_in      = 4'b0000;
        blank_in   = 4'b0000;
        value0     = 16'h3210;
        dp_in0     = 4'b0000;
        blank_in0  = 4'b0000;
        cur[0]     = OFF;
        cur[1]     = OFF;

        repeat (2) @(negedge clock);
        repeat (3) begin
            div_clock = 1'b1;
            repeat (3) @(negedge clock);
            check("rst_hold_hi", obs(0), OFF);
            div_clock = 1'b0;
            repeat (3) @(negedge clock);
            check("rst_hold_lo", obs(0), OFF);
        end

        value = 16'h1234;
        reset = 1'b1;
        repeat (5) @(negedge clock);
        tick_step(0, vec(4'b1110, 7'b0011001, 1'b1), "first_4");
        tick_step(0, vec(4'b1101, 7'b0110000, 1'b1), "first_3");
        tick_step(0, vec(4'b1011, 7'b0100100, 1'b1), "first_2");
        tick_step(0, vec(4'b0111, 7'b1111001, 1'b1), "first_1");

        value = 16'hA0F8;
        tick_step(0, vec(4'b1110, 7'b0000000, 1'b1), "scan_8");
        tick_step(0, vec(4'b1101, 7'b0001110, 1'b1), "scan_F");
        tick_step(0, vec(4'b1011, 7'b1000000, 1'b1), "scan_0");
        tick_step(0, vec(4'b0111, 7'b0001000, 1'b1), "scan_A");

        value = 16'h1111;
        tick_step(0, vec(4'b1110, 7'b1111001, 1'b1), "atom_d0");
        tick_step(0, vec(4'b1101, 7'b1111001, 1'b1), "atom_d1");
        value = 16'h2222;
        tick_step(0, vec(4'b1011, 7'b1111001, 1'b1), "atom_d2");
        tick_step(0, vec(4'b0111, 7'b1111001, 1'b1), "atom_d3");
        tick_step(0, vec(4'b1110, 7'b0100100, 1'b1), "atom_wrap");
        tick_step(0, vec(4'b1101, 7'b0100100, 1'b1), "atom_d1b");

        blank_in = 4'b0100;
        dp_in    = 4'b0001;
        tick_step(0, vec(4'b1011, 7'b0100100, 1'b1), "mask_old2");
        tick_step(0, vec(4'b0111, 7'b0100100, 1'b1), "mask_old3");
        tick_step(0, vec(4'b1110, 7'b0100100, 1'b0), "mask_dp0");
        tick_step(0, vec(4'b1101, 7'b0100100, 1'b1), "mask_d1");
        tick_step(0, OFF,                            "mask_d2");
        tick_step(0, vec(4'b0111, 7'b0100100, 1'b1), "mask_d3");

        blank_in = 4'b0000;
        dp_in    = 4'b0000;
        tick_step(0, vec(4'b1110, 7'b0100100, 1'b1), "pre_d0");
        tick_step(0, vec(4'b1101, 7'b0100100, 1'b1), "pre_d1");
        tick_step(0, vec(4'b1011, 7'b0100100, 1'b1), "pre_d2");

        #2 reset = 1'b0;
        #1 check("rst_async", obs(0), OFF);
        cur[0] = OFF;
        @(negedge clock);
        div_clock = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (15) begin
            @(negedge clock);
            check("rst_high_no_tick", obs(0), OFF);
        end
        div_clock = 1'b0;
        repeat (4) @(negedge clock);
        tick_step(0, vec(4'b1110, 7'b0100100, 1'b1), "restart_d0");

        tick_step(1, vec(4'b1110, 7'b1000000, 1'b1), "zb_d0");
        tick_step(1, vec(4'b1101, 7'b1111001, 1'b1), "zb_d1");
        tick_step(1, vec(4'b1011, 7'b0100100, 1'b1), "zb_d2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Four-digit seven-segment display scanner, directly downstream of the clock divider: consumes the divider's `div_clock` square wave as a scan-rate source, detects its rising edges in the system clock domain, and time-multiplexes a 16-bit hex value onto a common-anode display. It latches a full frame atomically, so digits never tear. It also inserts a configurable blanking gap between digits to suppress ghosting.

## Interface
- `BLANK_CYCLES`, default 8: system-clock cycles all anodes stay off between digits. Legal range 0..255; 0 disables blanking.
- `clock`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low; asserted when 0.
- `div_clock`  input  1  scan-rate square wave from the clock divider; asynchronous to this block's logic and always synchronized before use.
- `value`  input  16  hex value; digit i = `value[4i+3:4i]`, digit 0 rightmost.
- `dp_in`  input  4  decimal point per digit, active-high.
- `blank_in`  input  4  per-digit blank mask, active-high; a masked digit shows nothing during its slot.
- `anode`  output  4  active-low digit enables; `anode[i]` drives digit i.
- `seg`  output  7  active-low segments, `{g,f,e,d,c,b,a}`.
- `dp`  output  1  active-low decimal point.

## Operation
- Tick detection:
  - `div_clock` passes through a 2-flop synchronizer (`sync0`, `sync1`) followed by a `prev` flop.
  - `tick = sync1 & ~prev`, one cycle wide per rising edge of `div_clock`.
- State machine with states WAIT, BLANK, SHOW:
  - WAIT (reset state): all outputs off. On `tick`: capture frame, index = 0. Go to BLANK, or to SHOW if `BLANK_CYCLES == 0`.
  - BLANK: all outputs off; counter counts `BLANK_CYCLES` cycles, then go to SHOW. A `tick` arriving in BLANK is ignored; there is no queueing.
  - SHOW: drive digit `index`. On `tick`: index = (index+1) mod 4. If the new index is 0, capture the frame. Then go to BLANK, or stay in SHOW with the new digit if `BLANK_CYCLES == 0`.
- Frame capture: `value`, `dp_in` and `blank_in` are copied into frame registers in the same cycle the index becomes 0. Input changes between captures are invisible.
- SHOW outputs:
  - Digit driven: `anode` = one-cold at `index` unless `frame_blank[index]`; in that case `anode = 4'b1111`, `seg = 7'b1111111`, `dp = 1`.
  - Segment values: `seg` = hex decode of `frame_value` nibble `index`; `dp = ~frame_dp[index]`.
- Hex decode (active-low `{g..a}`):
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000
  - 4→0011001, 5→0010010, 6→0000010, 7→1111000
  - 8→0000000, 9→0010000, A→0001000, b→0000011
  - C→1000110, d→0100001, E→0000110, F→0001110
- All outputs are registered; no combinational path from any input to an output.
- Reset values:
  - `anode = 4'b1111`, `seg = 7'b1111111`, `dp = 1`.
  - State WAIT, index 0, blank counter 0.
  - Frame registers 0; `sync0`/`sync1`/`prev` 0.
- Reset mid-operation: everything returns to reset values immediately (asynchronous assertion). A `div_clock` already high at reset release produces no tick until it falls and rises again.

## Timing
- Tick latency:
  - `div_clock` first sampled high at edge k: `sync1` high after edge k+1, `tick` high during cycle k+1..k+2.
  - The state transition and the output change (anodes off, or new digit when `BLANK_CYCLES == 0`) are visible after edge k+2.
- BLANK length: new digit visible after edge k+2+`BLANK_CYCLES`. Anodes are off for exactly `BLANK_CYCLES` cycles.
- Anode hand-off: never more than one anode low in any cycle, including transitions with `BLANK_CYCLES == 0`.
- `div_clock` high or low phases shorter than 2 system clocks are not guaranteed to be detected.
- Full scan period = 4 `div_clock` periods.

## Test plan
- Reset and first frame: hold `reset=0` with `div_clock` toggling → outputs stay 1111/1111111/1. Release reset, `value=16'h1234`, first rising edge of `div_clock` → after `BLANK_CYCLES` (8) cycles of all-off, `anode=1110`, `seg=0011001` ("4").
- Full scan: `value=16'hA0F8`, 4 ticks → digits in order 8,F,0,A on anodes 1110,1101,1011,0111, with exactly 8 all-off cycles between each.
- Frame atomicity: change `value` from 16'h1111 to 16'h2222 while digit 1 is showing → digits 2,3 still show "1"; after wrap all digits show "2".
- Masks and decimal points: `blank_in=4'b0100`, `dp_in=4'b0001` → digit 2 slot all-off; digit 0 has `dp=0`, others `dp=1`.
- Zero blanking: build with `BLANK_CYCLES=0`, tick → anode moves directly from 1110 to 1101 at edge k+2, never two anodes low.
- Reset mid-scan: assert `reset` during SHOW of digit 2 → outputs off the same cycle (asynchronous). After release with `div_clock` already high, no digit appears until the next rising edge.
